// File: rtl/ysyx_25020042_exec_ctrl.sv
// Multi-cycle NPC sequencer: fetch, decode, execute, load access and writeback, one instruction
// at a time. Owns the PC and latches the instruction, load data and writeback result.
module ysyx_25020042_exec_ctrl #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned      TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ifu_req,
   output logic [WIDTH-1:0] ifu_addr,
   input  logic             ifu_rvalid,
   input  logic [31:0]      ifu_rdata,
   output logic [31:0]      inst,
   input  logic [7:0]       dec_op,
   output logic [7:0]       alu_op,
   output logic [WIDTH-1:0] ram_data,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_jump,
   input  logic [WIDTH-1:0] alu_pc_next,
   output logic             lsu_req,
   output logic [WIDTH-1:0] lsu_addr,
   input  logic             lsu_rvalid,
   input  logic [WIDTH-1:0] lsu_rdata,
   output logic             rf_wen,
   output logic [WIDTH-1:0] rf_wdata,
   output logic [WIDTH-1:0] pc,
   output logic             trap
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [7:0] OP_LOAD     = 8'h03;
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t           state, state_d;
   logic [WIDTH-1:0] pc_q;
   logic [31:0]      inst_q;
   logic [WIDTH-1:0] ram_data_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] lsu_addr_q;
   logic [7:0]       wait_cnt;
   logic             trap_q;
   logic             op_legal;
   logic             wait_expired;

   assign op_legal     = dec_op inside {8'h01, 8'h02, OP_LOAD};
   // A response in the same cycle the counter reaches TIMEOUT still wins over the trap.
   assign wait_expired = (wait_cnt == TIMEOUT_CNT);

   // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state;
      ifu_req = 1'b0;
      lsu_req = 1'b0;
      rf_wen  = 1'b0;
      alu_op  = 8'h00;
      case (state)
         S_FETCH: begin
            ifu_req = 1'b1;
            if (ifu_rvalid)        state_d = S_DECODE;
            else if (wait_expired) state_d = S_HALT;
         end
         S_DECODE: state_d = op_legal ? S_EXEC : S_HALT;
         S_EXEC: begin
            alu_op  = dec_op;
            state_d = (dec_op == OP_LOAD) ? S_MEM : S_WB;
         end
         S_MEM: begin
            lsu_req = 1'b1;
            alu_op  = OP_LOAD;
            if (lsu_rvalid)        state_d = S_WB;
            else if (wait_expired) state_d = S_HALT;
         end
         S_WB: begin
            rf_wen  = 1'b1;
            alu_op  = dec_op;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
      // Requests stay low for the whole reset interval, not just after the first edge.
      if (rst) begin
         ifu_req = 1'b0;
         lsu_req = 1'b0;
         rf_wen  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FETCH;
         pc_q       <= RESET_PC;
         inst_q     <= '0;
         ram_data_q <= '0;
         result_q   <= '0;
         lsu_addr_q <= '0;
         wait_cnt   <= '0;
         trap_q     <= 1'b0;
      end else begin
         state <= state_d;
         case (state)
            S_FETCH: begin
               if (ifu_rvalid)        inst_q   <= ifu_rdata;
               else if (wait_expired) trap_q   <= 1'b1;
               else                   wait_cnt <= wait_cnt + 8'd1;
            end
            S_DECODE: begin
               if (!op_legal) trap_q <= 1'b1;
            end
            S_EXEC: begin
               result_q <= alu_out;
               if (dec_op == OP_LOAD) begin
                  lsu_addr_q <= alu_out;
                  wait_cnt   <= '0;
               end
            end
            S_MEM: begin
               if (lsu_rvalid) begin
                  ram_data_q <= lsu_rdata;
                  result_q   <= lsu_rdata;
               end else if (wait_expired) begin
                  trap_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_WB: begin
               pc_q     <= alu_jump ? alu_pc_next : pc_q + WIDTH'(4);
               wait_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   assign ifu_addr = pc_q;
   assign pc       = pc_q;
   assign inst     = inst_q;
   assign ram_data = ram_data_q;
   assign lsu_addr = lsu_addr_q;
   assign rf_wdata = result_q;
   assign trap     = trap_q;

endmodule

// File: tb/tb_ysyx_25020042_exec_ctrl.sv
// Bench for ysyx_25020042_exec_ctrl: a per-instruction timeline model expands each instruction
// into expected per-cycle outputs plus memory stimulus; literal checks pin the model.
module tb_ysyx_25020042_exec_ctrl;

   localparam int          TIMEOUT  = 255;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req, ifu_rvalid, lsu_req, lsu_rvalid, rf_wen, trap, alu_jump;
   logic [31:0] ifu_addr, ifu_rdata, inst, ram_data, alu_out, alu_pc_next;
   logic [31:0] lsu_addr, lsu_rdata, rf_wdata, pc;
   logic [7:0]  dec_op, alu_op;

   ysyx_25020042_exec_ctrl dut (
      .clk(clk), .rst(rst),
      .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
      .inst(inst), .dec_op(dec_op), .alu_op(alu_op), .ram_data(ram_data),
      .alu_out(alu_out), .alu_jump(alu_jump), .alu_pc_next(alu_pc_next),
      .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .rf_wen(rf_wen), .rf_wdata(rf_wdata), .pc(pc), .trap(trap)
   );

   always #5 clk = ~clk;

   // Toy decoder/ALU: op in inst[7:0], value in inst[31:8], op 02 jumps to RESET_PC|value.
   assign dec_op      = inst[7:0];
   assign alu_out     = {8'h00, inst[31:8]};
   assign alu_jump    = (inst[7:0] == 8'h02);
   assign alu_pc_next = RESET_PC | alu_out;

   typedef struct packed {
      logic        ifu_rvalid;
      logic [31:0] ifu_rdata;
      logic        lsu_rvalid;
      logic [31:0] lsu_rdata;
      logic        ifu_req;
      logic        lsu_req;
      logic [31:0] lsu_addr;
      logic        rf_wen;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic        trap;
      logic        chk_aop;
      logic [7:0]  aop;
      logic        chk_inst;
      logic [31:0] exp_inst;
   } cyc_t;

   cyc_t        plan[$];
   logic [31:0] m_pc;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] wb_pc[$];
   logic [31:0] wb_data[$];
   int          wb_cyc[$];
   logic [31:0] lsu_log[$];
   int          first_trap;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic cyc_t idle_cyc();
      cyc_t c;
      c    = '0;
      c.pc = m_pc;
      return c;
   endfunction

   // Halted core: responses are offered every cycle and must all be ignored.
   task automatic add_halt(input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c            = idle_cyc();
         c.trap       = 1'b1;
         c.chk_aop    = 1'b1;
         c.ifu_rvalid = 1'b1;
         c.ifu_rdata  = 32'hFFFF_FFFF;
         c.lsu_rvalid = 1'b1;
         c.lsu_rdata  = 32'hFFFF_FFFF;
         plan.push_back(c);
      end
   endtask

   // fw/mw: cycles before the fetch/load response; above TIMEOUT means it never comes.
   task automatic add_inst(input logic [31:0] word, input int fw, input int mw, input logic [31:0] rdata);
      logic [7:0]  op;
      logic [31:0] val;
      cyc_t        c;
      op  = word[7:0];
      val = {8'h00, word[31:8]};
      for (int k = 0; k <= TIMEOUT && k <= fw; k++) begin
         c         = idle_cyc();
         c.ifu_req = 1'b1;
         c.chk_aop = 1'b1;
         if (k == fw) begin
            c.ifu_rvalid = 1'b1;
            c.ifu_rdata  = word;
         end
         plan.push_back(c);
      end
      if (fw > TIMEOUT) begin
         add_halt(20);
         return;
      end
      c            = idle_cyc();
      c.chk_aop    = 1'b1;
      c.chk_inst   = 1'b1;
      c.exp_inst   = word;
      c.ifu_rvalid = 1'b1;
      c.ifu_rdata  = 32'hFFFF_FFFF;
      plan.push_back(c);
      if (!(op inside {8'h01, 8'h02, 8'h03})) begin
         add_halt(20);
         return;
      end
      c          = idle_cyc();
      c.chk_aop  = 1'b1;
      c.aop      = op;
      c.chk_inst = 1'b1;
      c.exp_inst = word;
      plan.push_back(c);
      if (op == 8'h03) begin
         for (int k = 0; k <= TIMEOUT && k <= mw; k++) begin
            c          = idle_cyc();
            c.lsu_req  = 1'b1;
            c.lsu_addr = val;
            c.chk_aop  = 1'b1;
            c.aop      = 8'h03;
            c.chk_inst = 1'b1;
            c.exp_inst = word;
            if (k == mw) begin
               c.lsu_rvalid = 1'b1;
               c.lsu_rdata  = rdata;
            end
            plan.push_back(c);
         end
         if (mw > TIMEOUT) begin
            add_halt(20);
            return;
         end
      end
      c          = idle_cyc();
      c.rf_wen   = 1'b1;
      c.wdata    = (op == 8'h03) ? rdata : val;
      c.chk_inst = 1'b1;
      c.exp_inst = word;
      plan.push_back(c);
      m_pc = (op == 8'h02) ? (RESET_PC | val) : m_pc + 32'd4;
   endtask

   // Entered at a negedge; samples outputs 1ns later, then drives that cycle's responses.
   task automatic run_plan(input int limit);
      cyc_t c;
      int   n = 0;
      while (plan.size() > 0 && n < limit) begin
         c = plan.pop_front();
         #1;
         check($sformatf("c%0d ifu_req", n), 32'(ifu_req), 32'(c.ifu_req));
         check($sformatf("c%0d lsu_req", n), 32'(lsu_req), 32'(c.lsu_req));
         check($sformatf("c%0d rf_wen", n), 32'(rf_wen), 32'(c.rf_wen));
         check($sformatf("c%0d trap", n), 32'(trap), 32'(c.trap));
         check($sformatf("c%0d pc", n), pc, c.pc);
         check($sformatf("c%0d ifu_addr", n), ifu_addr, c.pc);
         if (c.lsu_req)  check($sformatf("c%0d lsu_addr", n), lsu_addr, c.lsu_addr);
         if (c.rf_wen)   check($sformatf("c%0d rf_wdata", n), rf_wdata, c.wdata);
         if (c.chk_aop)  check($sformatf("c%0d alu_op", n), 32'(alu_op), 32'(c.aop));
         if (c.chk_inst) check($sformatf("c%0d inst", n), inst, c.exp_inst);
         if (rf_wen) begin
            wb_pc.push_back(pc);
            wb_data.push_back(rf_wdata);
            wb_cyc.push_back(n);
         end
         if (lsu_req) lsu_log.push_back(lsu_addr);
         if (trap && first_trap < 0) first_trap = n;
         ifu_rvalid = c.ifu_rvalid;
         ifu_rdata  = c.ifu_rdata;
         lsu_rvalid = c.lsu_rvalid;
         lsu_rdata  = c.lsu_rdata;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic clear_logs();
      plan.delete();
      wb_pc.delete();
      wb_data.delete();
      wb_cyc.delete();
      lsu_log.delete();
      first_trap = -1;
      m_pc       = RESET_PC;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      ifu_rvalid = 1'b0;
      ifu_rdata  = '0;
      lsu_rvalid = 1'b0;
      lsu_rdata  = '0;
      @(negedge clk);
      #1;
      check("reset ifu_req", 32'(ifu_req), 32'd0);
      check("reset lsu_req", 32'(lsu_req), 32'd0);
      check("reset rf_wen", 32'(rf_wen), 32'd0);
      check("reset trap", 32'(trap), 32'd0);
      check("reset pc", pc, RESET_PC);
      check("reset inst", inst, 32'd0);
      check("reset ram_data", ram_data, 32'd0);
      check("reset rf_wdata", rf_wdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end within time limit");
      $fatal(1);
   end

   initial begin
      cyc_t c;

      // addi, load with waits, jump, addi after jump, fetch answered in the TIMEOUT cycle, illegal op
      do_reset();
      add_inst(32'h0000_0501, 0,   0, 32'h0);
      add_inst(32'h0001_0003, 2,   3, 32'h0000_DEAD);
      add_inst(32'h0010_0002, 0,   0, 32'h0);
      add_inst(32'h0000_0701, 1,   0, 32'h0);
      add_inst(32'h0000_4002, 255, 0, 32'h0);
      add_inst(32'h0000_007F, 0,   0, 32'h0);
      run_plan(2000);
      check("s1 wb count", 32'(wb_data.size()), 32'd5);
      if (wb_data.size() == 5) begin
         check("addi wdata", wb_data[0], 32'd5);
         check("addi pc", wb_pc[0], 32'h8000_0000);
         check("addi latency", 32'(wb_cyc[0]), 32'd3);
         check("load wdata", wb_data[1], 32'h0000_DEAD);
         check("load wb cycle", 32'(wb_cyc[1]), 32'd13);
         check("jump link wdata", wb_data[2], 32'h0000_1000);
         check("after-jump pc", wb_pc[3], 32'h8000_1000);
         check("after-jump wdata", wb_data[3], 32'd7);
         check("late fetch wb cycle", 32'(wb_cyc[4]), 32'd281);
      end
      check("load lsu_addr", lsu_log.size() > 0 ? lsu_log[0] : 32'hX, 32'h0000_0100);
      check("load ram_data", ram_data, 32'h0000_DEAD);
      check("illegal trap", 32'(trap), 32'd1);
      check("illegal pc frozen", pc, 32'h8000_0040);
      check("illegal trap cycle", 32'(first_trap), 32'd284);

      // fetch never answered
      do_reset();
      add_inst(32'h0000_0501, 300, 0, 32'h0);
      run_plan(2000);
      check("fetch timeout trap cycle", 32'(first_trap), 32'd256);
      check("fetch timeout no wb", 32'(wb_data.size()), 32'd0);
      check("fetch timeout pc", pc, RESET_PC);

      // load never answered
      do_reset();
      add_inst(32'h0001_0003, 0, 300, 32'h0);
      run_plan(2000);
      check("load timeout trap cycle", 32'(first_trap), 32'd259);
      check("load timeout no wb", 32'(wb_data.size()), 32'd0);

      // reset while a load is outstanding; the stale response lands after reset
      do_reset();
      add_inst(32'h0001_0003, 0, 10, 32'h0);
      run_plan(5);
      #1;
      check("pre-reset lsu_req", 32'(lsu_req), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid-MEM rst lsu_req", 32'(lsu_req), 32'd0);
      check("mid-MEM rst ifu_req", 32'(ifu_req), 32'd0);
      check("mid-MEM rst pc", pc, RESET_PC);
      lsu_rvalid = 1'b1;
      lsu_rdata  = 32'h0000_0BAD;
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
      add_inst(32'h0000_0501, 0, 0, 32'h0);
      c            = plan.pop_front();
      c.lsu_rvalid = 1'b1;
      c.lsu_rdata  = 32'h0000_0BAD;
      plan.push_front(c);
      add_inst(32'h0000_0301, 0, 0, 32'h0);
      run_plan(100);
      check("restart wb count", 32'(wb_data.size()), 32'd2);
      check("restart wdata", wb_data.size() > 0 ? wb_data[0] : 32'hX, 32'd5);
      check("restart pc", pc, 32'h8000_0008);
      check("restart ram_data untouched", ram_data, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
